random_word_selector: RTL and testbench

- Consumer end of the random-number interface.
- Strobes the RandomNumberGenerator's `grabWord` input and samples its 7-bit `random_num`.
- Rejects out-of-range indices and indices repeated within the recent history.
- Presents one accepted word index per request over a valid/ready handshake to the game/word-lookup logic.

---
 rtl/random_word_selector.sv | 130 +++++++++++++
 tb/tb_random_word_selector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/random_word_selector.sv
// Consumer of the RNG: strobes grab_word, samples random_num and rejects out-of-range or
// recently delivered indices. Delivers one accepted index per start over valid/ready.
module random_word_selector #(
   parameter int WORD_COUNT    = 100,
   parameter int HISTORY_DEPTH = 4,
   parameter int MAX_TRIES     = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] random_num,
   output logic       grab_word,
   output logic [6:0] word_index,
   output logic       word_valid,
   input  logic       word_ready,
   output logic       fallback,
   output logic       busy
);

   // state   | meaning
   // IDLE    | waiting for start
   // GRAB    | grab_word strobe to the RNG
   // WAIT    | RNG settling cycle
   // SAMPLE  | capture random_num into cand
   // CHECK   | accept, retry or force the fallback index
   // PRESENT | word_valid high until word_ready
   typedef enum logic [2:0] {
      S_IDLE, S_GRAB, S_WAIT, S_SAMPLE, S_CHECK, S_PRESENT
   } state_t;

   localparam logic [7:0] WC8 = 8'(WORD_COUNT);
   localparam logic [4:0] MT5 = 5'(MAX_TRIES);

   state_t                   state_q;
   logic [6:0]               cand_q;
   logic [3:0]               tries_q;
   logic                     grab_q;
   logic                     valid_q;
   logic                     fb_q;
   logic [6:0]               idx_q;
   logic [6:0]               hist_q [HISTORY_DEPTH];
   logic [HISTORY_DEPTH-1:0] hist_vld_q;

   logic                     in_range_d;
   logic                     hist_hit_d;
   logic                     last_try_d;
   logic [6:0]               fb_idx_d;

   always_comb begin
      in_range_d = ({1'b0, cand_q} < WC8);
      hist_hit_d = 1'b0;
      for (int i = 0; i < HISTORY_DEPTH; i++) begin
         if (hist_vld_q[i] && (hist_q[i] == cand_q)) hist_hit_d = 1'b1;
      end
   end

   assign last_try_d = (({1'b0, tries_q} + 5'd1) == MT5);
   // WORD_COUNT >= 64, so a single wrap brings any 7-bit value into range
   assign fb_idx_d   = in_range_d ? cand_q : 7'({1'b0, cand_q} - WC8);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cand_q     <= '0;
         tries_q    <= '0;
         grab_q     <= 1'b0;
         valid_q    <= 1'b0;
         fb_q       <= 1'b0;
         idx_q      <= '0;
         hist_vld_q <= '0;
         for (int i = 0; i < HISTORY_DEPTH; i++) hist_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_GRAB;
                  grab_q  <= 1'b1;
                  tries_q <= '0;
               end
            end
            S_GRAB: begin
               grab_q  <= 1'b0;
               state_q <= S_WAIT;
            end
            S_WAIT: state_q <= S_SAMPLE;
            S_SAMPLE: begin
               cand_q  <= random_num;
               state_q <= S_CHECK;
            end
            S_CHECK: begin
               if (in_range_d && !hist_hit_d) begin
                  idx_q   <= cand_q;
                  fb_q    <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= S_PRESENT;
               end else if (last_try_d) begin
                  idx_q   <= fb_idx_d;
                  fb_q    <= 1'b1;
                  valid_q <= 1'b1;
                  state_q <= S_PRESENT;
               end else begin
                  tries_q <= tries_q + 4'd1;
                  grab_q  <= 1'b1;
                  state_q <= S_GRAB;
               end
            end
            S_PRESENT: begin
               if (word_ready) begin
                  valid_q <= 1'b0;
                  for (int i = HISTORY_DEPTH - 1; i > 0; i--) begin
                     hist_q[i]     <= hist_q[i-1];
                     hist_vld_q[i] <= hist_vld_q[i-1];
                  end
                  hist_q[0]     <= idx_q;
                  hist_vld_q[0] <= 1'b1;
                  state_q       <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign grab_word  = grab_q;
   assign word_index = idx_q;
   assign word_valid = valid_q;
   assign fallback   = fb_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_random_word_selector.sv
// Bench for random_word_selector: an RNG stand-in feeds queued samples, and a queue-based
// history model predicts index, fallback flag, latency and grab count per request.
module tb_random_word_selector;

   localparam int WORD_COUNT    = 100;
   localparam int HISTORY_DEPTH = 4;
   localparam int MAX_TRIES     = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic       start = 1'b0;
   logic [6:0] random_num = '0;
   logic       grab_word;
   logic [6:0] word_index;
   logic       word_valid;
   logic       word_ready = 1'b1;
   logic       fallback;
   logic       busy;

   int         n_vec = 0;
   int         n_err = 0;
   int         grab_cnt = 0;
   int         rng_dly = 0;
   logic [6:0] rng_q[$];
   logic [6:0] rng_dflt = 7'd127;
   int         hist[$];

   random_word_selector #(
      .WORD_COUNT(WORD_COUNT), .HISTORY_DEPTH(HISTORY_DEPTH), .MAX_TRIES(MAX_TRIES)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .random_num(random_num),
      .grab_word(grab_word), .word_index(word_index), .word_valid(word_valid),
      .word_ready(word_ready), .fallback(fallback), .busy(busy)
   );

   always #5 clk = ~clk;

   // RNG stand-in: junk until the second cycle after the strobe, then the next queued value
   always @(negedge clk) begin
      if (grab_word) begin
         grab_cnt++;
         random_num = 7'($urandom);
         rng_dly = 2;
      end else if (rng_dly > 0) begin
         rng_dly--;
         if (rng_dly == 0) begin
            if (rng_q.size() > 0) random_num = rng_q.pop_front();
            else random_num = rng_dflt;
         end
      end
   end

   task automatic do_request(input string name, input int ready_delay);
      logic [6:0] s[$];
      logic [6:0] v;
      logic [6:0] exp_idx;
      logic [6:0] held;
      bit         exp_fb;
      bit         hit;
      bit         done;
      int         idx;
      int         samples;
      int         n;
      int         g0;
      s = rng_q;
      idx = 0;
      samples = 0;
      done = 0;
      exp_idx = '0;
      exp_fb = 0;
      while (!done) begin
         v = (idx < s.size()) ? s[idx] : rng_dflt;
         idx++;
         samples++;
         hit = 0;
         foreach (hist[j]) if (hist[j] == int'(v)) hit = 1;
         if (int'(v) < WORD_COUNT && !hit) begin
            exp_idx = v; exp_fb = 0; done = 1;
         end else if (samples == MAX_TRIES) begin
            exp_fb = 1;
            exp_idx = (int'(v) < WORD_COUNT) ? v : 7'(int'(v) - WORD_COUNT);
            done = 1;
         end
      end

      word_ready = (ready_delay == 0);
      @(negedge clk);
      g0 = grab_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!word_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_vec++;
      if (n != 4 * samples + 1) begin
         n_err++;
         $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, 4 * samples + 1);
      end
      n_vec++;
      if (word_index !== exp_idx) begin
         n_err++;
         $display("FAIL %s word_index: got %0d, expected %0d", name, word_index, exp_idx);
      end
      n_vec++;
      if (fallback !== exp_fb) begin
         n_err++;
         $display("FAIL %s fallback: got %0b, expected %0b", name, fallback, exp_fb);
      end
      n_vec++;
      if (grab_cnt - g0 != samples) begin
         n_err++;
         $display("FAIL %s grab pulses: got %0d, expected %0d", name, grab_cnt - g0, samples);
      end
      held = word_index;
      for (int c = 0; c < ready_delay; c++) begin
         start = ~start;
         @(negedge clk);
         n_vec++;
         if (word_valid !== 1'b1 || word_index !== held || fallback !== exp_fb
             || grab_cnt - g0 != samples) begin
            n_err++;
            $display("FAIL %s hold cycle %0d: valid=%0b idx=%0d grabs=%0d, expected valid=1 idx=%0d grabs=%0d",
                     name, c, word_valid, word_index, grab_cnt - g0, held, samples);
         end
      end
      start = 1'b0;
      word_ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (word_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s after handshake: valid=%0b busy=%0b, expected 0 0", name, word_valid, busy);
      end
      hist.push_front(int'(exp_idx));
      if (hist.size() > HISTORY_DEPTH) void'(hist.pop_back());
      rng_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (grab_word !== 1'b0) begin n_err++; $display("FAIL reset grab_word: got %0b, expected 0", grab_word); end
      n_vec++;
      if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset word_valid: got %0b, expected 0", word_valid); end
      n_vec++;
      if (fallback !== 1'b0) begin n_err++; $display("FAIL reset fallback: got %0b, expected 0", fallback); end
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %0b, expected 0", busy); end
      n_vec++;
      if (word_index !== 7'd0) begin n_err++; $display("FAIL reset word_index: got %0d, expected 0", word_index); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || word_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset release: busy=%0b valid=%0b, expected 0 0", busy, word_valid);
      end
   endtask

   task automatic test_first_try();
      rng_q = '{7'd37};
      do_request("first_try", 0);
   endtask

   task automatic test_out_of_range();
      rng_q = '{7'd120, 7'd5};
      do_request("out_of_range", 0);
   endtask

   task automatic test_history();
      for (int w = 10; w <= 13; w++) begin
         rng_q = '{7'(w)};
         do_request("history_fill", 0);
      end
      rng_q = '{7'd10, 7'd14};
      do_request("history_reject", 0);
      rng_q = '{7'd10};
      do_request("history_aged_out", 0);
   endtask

   task automatic test_fallback();
      rng_dflt = 7'd127;
      rng_q.delete();
      do_request("fallback", 0);
   endtask

   task automatic test_backpressure();
      rng_q = '{7'd50};
      do_request("backpressure", 20);
      rng_q = '{7'd14, 7'd61};
      do_request("backpressure_history", 0);
   endtask

   task automatic test_mid_retry_reset();
      int g0;
      int valids;
      rng_dflt = 7'd127;
      rng_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      reset = 1'b0;
      #1;
      n_vec++;
      if (busy !== 1'b0 || grab_word !== 1'b0 || word_valid !== 1'b0 || fallback !== 1'b0
          || word_index !== 7'd0) begin
         n_err++;
         $display("FAIL mid_reset outputs: busy=%0b grab=%0b valid=%0b fb=%0b idx=%0d, expected all 0",
                  busy, grab_word, word_valid, fallback, word_index);
      end
      @(negedge clk);
      reset = 1'b1;
      hist.delete();
      g0 = grab_cnt;
      valids = 0;
      repeat (80) begin
         @(negedge clk);
         if (word_valid) valids++;
      end
      n_vec++;
      if (valids != 0 || grab_cnt != g0) begin
         n_err++;
         $display("FAIL mid_reset aftermath: valid cycles=%0d grabs=%0d, expected 0 0", valids, grab_cnt - g0);
      end
      rng_q = '{7'd50};
      do_request("post_reset_history_cleared", 0);
   endtask

   task automatic test_random();
      int ns;
      for (int it = 0; it < 12; it++) begin
         ns = $urandom_range(1, 3);
         for (int k = 0; k < ns; k++) begin
            if (hist.size() > 0 && $urandom_range(0, 1) == 1)
               rng_q.push_back(7'(hist[$urandom_range(0, hist.size() - 1)]));
            else
               rng_q.push_back(7'($urandom_range(0, 127)));
         end
         rng_dflt = 7'($urandom_range(0, 127));
         do_request("random", $urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_first_try();
      test_out_of_range();
      test_history();
      test_fallback();
      test_backpressure();
      test_mid_retry_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
